// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hcu_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Any nonzero MemRead encoding marks a load in EXE.
    function automatic logic is_load(input logic [3:0] mem_read);
        return mem_read != 4'd0;
    endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: load-use stalls, EXE redirects and data-memory waits,
// with stall/flush counters and a sticky memory-timeout flag.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int LOAD_BUBBLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       MemRead_ID_EXE,
    input  logic [4:0]       rd_EXE,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             use_rs1_ID,
    input  logic             use_rs2_ID,
    input  logic             redirect_EXE,
    input  logic             dmem_busy,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_flush,
    output logic             ID_EXE_REG_Write,
    output logic             ID_EXE_flush,
    output logic             EXE_MEM_Write,
    output logic             MEM_WB_flush,
    output logic [1:0]       state_dbg,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [1:0]      LB        = 2'(LOAD_BUBBLES);

    hcu_state_t        state, ret, eff_state;
    logic [1:0]        bubble_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              hz, ev_redirect, ev_stall;

    assign hz = is_load(MemRead_ID_EXE) && (rd_EXE != REG_X0) &&
                ((use_rs1_ID && (rs1_ID == rd_EXE)) || (use_rs2_ID && (rs2_ID == rd_EXE)));

    // Leaving MEM_WAIT, this cycle behaves as the state that was interrupted.
    assign eff_state   = (state == MEM_WAIT) ? ret : state;
    assign ev_redirect = !dmem_busy && redirect_EXE;
    assign ev_stall    = !dmem_busy && !redirect_EXE && (hz || (eff_state == LU_STALL));

    always_comb begin
        PC_Write         = 1'b1;
        IF_ID_Write      = 1'b1;
        IF_ID_flush      = 1'b0;
        ID_EXE_REG_Write = 1'b1;
        ID_EXE_flush     = 1'b0;
        EXE_MEM_Write    = 1'b1;
        MEM_WB_flush     = 1'b0;
        state_dbg        = state;
        if (reset_n) begin
            PC_Write         = 1'b0;
            IF_ID_Write      = 1'b0;
            IF_ID_flush      = 1'b1;
            ID_EXE_REG_Write = 1'b0;
            ID_EXE_flush     = 1'b1;
            EXE_MEM_Write    = 1'b0;
            MEM_WB_flush     = 1'b1;
            state_dbg        = RUN;
        end else if (dmem_busy) begin
            PC_Write         = 1'b0;
            IF_ID_Write      = 1'b0;
            ID_EXE_REG_Write = 1'b0;
            EXE_MEM_Write    = 1'b0;
            MEM_WB_flush     = 1'b1;
        end else if (ev_redirect) begin
            IF_ID_flush  = 1'b1;
            ID_EXE_flush = 1'b1;
        end else if (ev_stall) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EXE_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state       <= RUN;
            ret         <= RUN;
            bubble_cnt  <= 2'd0;
            mem_timeout <= 1'b0;
        end else if (dmem_busy) begin
            if (state != MEM_WAIT) begin
                ret   <= state;
                state <= MEM_WAIT;
            end
            if (wait_cnt >= WAIT_LAST) begin
                mem_timeout <= 1'b1;
            end
        end else if (redirect_EXE) begin
            state      <= RUN;
            bubble_cnt <= 2'd0;
        end else if (eff_state == LU_STALL) begin
            if ((bubble_cnt + 2'd1) >= LB) begin
                state      <= RUN;
                bubble_cnt <= 2'd0;
            end else begin
                state      <= LU_STALL;
                bubble_cnt <= bubble_cnt + 2'd1;
            end
        end else if (hz && (LOAD_BUBBLES >= 2)) begin
            state      <= LU_STALL;
            bubble_cnt <= 2'd1;
        end else begin
            state <= RUN;
        end
    end

    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk (clk),
        .clr (reset_n || !dmem_busy),
        .inc (dmem_busy),
        .cnt (wait_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (reset_n),
        .inc (!PC_Write),
        .cnt (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .clr (reset_n),
        .inc (ev_redirect),
        .cnt (flush_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: one instance with single-bubble loads, one with two.
module tb_hazard_control_unit;

    typedef struct packed {
        logic [3:0] mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       redir;
        logic       busy;
    } in_t;

    typedef struct {
        in_t        in;
        logic [8:0] exp;
        string      name;
    } vec_t;

    // Control word: {state_dbg, PC_W, IFID_W, IFID_fl, IDEXE_W, IDEXE_fl, EXEMEM_W, MEMWB_fl}
    localparam logic [6:0] C_DEF  = 7'b1101010;
    localparam logic [6:0] C_HZ   = 7'b0001110;
    localparam logic [6:0] C_RED  = 7'b1111110;
    localparam logic [6:0] C_BUSY = 7'b0000001;
    localparam logic [6:0] C_RST  = 7'b0010101;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] mem_read;
    logic [4:0] rd_exe, rs1_id, rs2_id;
    logic       use_rs1, use_rs2, redirect, dmem_busy;

    logic        d1_pcw, d1_ifw, d1_iff, d1_idw, d1_idf, d1_exw, d1_mwf, d1_to;
    logic [1:0]  d1_st;
    logic [31:0] d1_stall, d1_flush;
    logic        d2_pcw, d2_ifw, d2_iff, d2_idw, d2_idf, d2_exw, d2_mwf, d2_to;
    logic [1:0]  d2_st;
    logic [31:0] d2_stall, d2_flush;

    wire [8:0] ctl1 = {d1_st, d1_pcw, d1_ifw, d1_iff, d1_idw, d1_idf, d1_exw, d1_mwf};
    wire [8:0] ctl2 = {d2_st, d2_pcw, d2_ifw, d2_iff, d2_idw, d2_idf, d2_exw, d2_mwf};

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    int         sel_q[$];
    string      name_q[$];

    vec_t tab[9];

    always #5 clk = ~clk;

    hazard_control_unit #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(8), .CNT_W(32)) dut1 (
        .clk(clk), .reset_n(reset_n), .MemRead_ID_EXE(mem_read), .rd_EXE(rd_exe),
        .rs1_ID(rs1_id), .rs2_ID(rs2_id), .use_rs1_ID(use_rs1), .use_rs2_ID(use_rs2),
        .redirect_EXE(redirect), .dmem_busy(dmem_busy),
        .PC_Write(d1_pcw), .IF_ID_Write(d1_ifw), .IF_ID_flush(d1_iff),
        .ID_EXE_REG_Write(d1_idw), .ID_EXE_flush(d1_idf), .EXE_MEM_Write(d1_exw),
        .MEM_WB_flush(d1_mwf), .state_dbg(d1_st), .stall_count(d1_stall),
        .flush_count(d1_flush), .mem_timeout(d1_to)
    );

    hazard_control_unit #(.LOAD_BUBBLES(2), .MEM_TIMEOUT(8), .CNT_W(32)) dut2 (
        .clk(clk), .reset_n(reset_n), .MemRead_ID_EXE(mem_read), .rd_EXE(rd_exe),
        .rs1_ID(rs1_id), .rs2_ID(rs2_id), .use_rs1_ID(use_rs1), .use_rs2_ID(use_rs2),
        .redirect_EXE(redirect), .dmem_busy(dmem_busy),
        .PC_Write(d2_pcw), .IF_ID_Write(d2_ifw), .IF_ID_flush(d2_iff),
        .ID_EXE_REG_Write(d2_idw), .ID_EXE_flush(d2_idf), .EXE_MEM_Write(d2_exw),
        .MEM_WB_flush(d2_mwf), .state_dbg(d2_st), .stall_count(d2_stall),
        .flush_count(d2_flush), .mem_timeout(d2_to)
    );

    function automatic in_t mk(input logic [3:0] m, input logic [4:0] d, input logic [4:0] s1,
                               input logic [4:0] s2, input logic a, input logic b,
                               input logic r, input logic bz);
        in_t v;
        v.mr = m; v.rd = d; v.rs1 = s1; v.rs2 = s2;
        v.u1 = a; v.u2 = b; v.redir = r; v.busy = bz;
        return v;
    endfunction

    function automatic logic [8:0] cw(input logic [1:0] st, input logic [6:0] c);
        return {st, c};
    endfunction

    task automatic drive(input in_t v);
        mem_read  = v.mr;
        rd_exe    = v.rd;
        rs1_id    = v.rs1;
        rs2_id    = v.rs2;
        use_rs1   = v.u1;
        use_rs2   = v.u2;
        redirect  = v.redir;
        dmem_busy = v.busy;
    endtask

    task automatic check_scoreboard();
        logic [8:0] e, a;
        int         s;
        string      n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            s = sel_q.pop_front();
            n = name_q.pop_front();
            a = (s == 1) ? ctl1 : ctl2;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s dut%0d ctl got %b exp %b", n, s, a, e);
            end
        end
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", n, act, exp);
        end
    endtask

    // One cycle: drive after the edge, queue expectations, compare at the falling edge.
    task automatic step(input string n, input in_t v, input logic c1, input logic [8:0] e1,
                        input logic c2, input logic [8:0] e2);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        drive(v);
        if (c1) begin exp_q.push_back(e1); sel_q.push_back(1); name_q.push_back(n); end
        if (c2) begin exp_q.push_back(e2); sel_q.push_back(2); name_q.push_back(n); end
        @(negedge clk);
        check_scoreboard();
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            reset_n = 1'b1;
            drive(mk(4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(cw(2'd0, C_RST)); sel_q.push_back(1); name_q.push_back("reset");
            exp_q.push_back(cw(2'd0, C_RST)); sel_q.push_back(2); name_q.push_back("reset");
            @(negedge clk);
            check_scoreboard();
        end
    endtask

    in_t idle, hz5, hzbusy, busy_only, redhz;
    int  exp_st1;

    initial begin
        idle      = mk(4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        hz5       = mk(4'b0100, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        hzbusy    = mk(4'b0100, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        busy_only = mk(4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        redhz     = mk(4'b0100, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);

        tab[0] = '{mk(4'd0,    5'd5,  5'd0, 5'd5,  1'b0, 1'b1, 1'b0, 1'b0), cw(2'd0, C_DEF), "no_load"};
        tab[1] = '{mk(4'b0100, 5'd5,  5'd0, 5'd5,  1'b0, 1'b1, 1'b0, 1'b0), cw(2'd0, C_HZ),  "hz_rs2"};
        tab[2] = '{mk(4'b0100, 5'd0,  5'd0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0), cw(2'd0, C_DEF), "rd_x0"};
        tab[3] = '{mk(4'b0100, 5'd5,  5'd5, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0), cw(2'd0, C_DEF), "rs1_unused"};
        tab[4] = '{mk(4'b0010, 5'd7,  5'd7, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0), cw(2'd0, C_HZ),  "hz_rs1"};
        tab[5] = '{mk(4'b0010, 5'd7,  5'd3, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0), cw(2'd0, C_DEF), "no_match"};
        tab[6] = '{mk(4'b0100, 5'd5,  5'd5, 5'd5,  1'b1, 1'b1, 1'b1, 1'b0), cw(2'd0, C_RED), "redir_hz"};
        tab[7] = '{mk(4'd0,    5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0), cw(2'd0, C_RED), "redir"};
        tab[8] = '{mk(4'b1000, 5'd31, 5'd2, 5'd31, 1'b0, 1'b1, 1'b0, 1'b0), cw(2'd0, C_HZ),  "hz_x31"};

        reset_n = 1'b1;
        drive(idle);
        do_reset(2);
        step("post_reset", idle, 1'b1, cw(2'd0, C_DEF), 1'b1, cw(2'd0, C_DEF));
        chk("reset_stall_cnt", d1_stall, 32'd0);
        chk("reset_timeout", {31'd0, d1_to}, 32'd0);

        // Single-cycle vectors against the single-bubble instance.
        for (int i = 0; i < 9; i++) begin
            step(tab[i].name, tab[i].in, 1'b1, tab[i].exp, 1'b0, '0);
        end
        for (int i = 0; i < 6; i++) begin
            step("rand_idle",
                 mk(4'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b0, 1'b0),
                 1'b1, cw(2'd0, C_DEF), 1'b0, '0);
        end
        step("idle", idle, 1'b1, cw(2'd0, C_DEF), 1'b0, '0);
        chk("tab_stall_cnt", d1_stall, 32'd3);
        chk("tab_flush_cnt", d1_flush, 32'd2);

        // Reset while the two-bubble instance sits in LU_STALL.
        step("enter_lu", hz5, 1'b0, '0, 1'b1, cw(2'd0, C_HZ));
        do_reset(3);
        step("rel_reset", idle, 1'b1, cw(2'd0, C_DEF), 1'b1, cw(2'd0, C_DEF));
        chk("rel_stall_cnt2", d2_stall, 32'd0);
        chk("rel_flush_cnt2", d2_flush, 32'd0);

        // Load-use with one and with two bubbles.
        step("lu_c1", hz5,  1'b1, cw(2'd0, C_HZ),  1'b1, cw(2'd0, C_HZ));
        step("lu_c2", idle, 1'b1, cw(2'd0, C_DEF), 1'b1, cw(2'd1, C_HZ));
        step("lu_c3", idle, 1'b1, cw(2'd0, C_DEF), 1'b1, cw(2'd0, C_DEF));
        chk("lu_stall_cnt1", d1_stall, 32'd1);
        chk("lu_stall_cnt2", d2_stall, 32'd2);

        // Redirect squashes a simultaneous hazard.
        step("red_hz", redhz, 1'b1, cw(2'd0, C_RED), 1'b1, cw(2'd0, C_RED));
        step("red_after", idle, 1'b1, cw(2'd0, C_DEF), 1'b1, cw(2'd0, C_DEF));
        chk("red_flush_cnt2", d2_flush, 32'd1);
        chk("red_stall_cnt2", d2_stall, 32'd2);

        // Memory wait in the middle of a two-bubble stall.
        do_reset(1);
        step("mw_hz", hz5, 1'b1, cw(2'd0, C_HZ), 1'b1, cw(2'd0, C_HZ));
        for (int k = 1; k <= 4; k++) begin
            step("mw_busy", hzbusy, 1'b1, cw((k == 1) ? 2'd0 : 2'd2, C_BUSY),
                 1'b1, cw((k == 1) ? 2'd1 : 2'd2, C_BUSY));
        end
        step("mw_exit", idle, 1'b1, cw(2'd2, C_DEF), 1'b1, cw(2'd2, C_HZ));
        step("mw_done", idle, 1'b1, cw(2'd0, C_DEF), 1'b1, cw(2'd0, C_DEF));
        chk("mw_stall_cnt2", d2_stall, 32'd6);
        chk("mw_stall_cnt1", d1_stall, 32'd5);

        // Timeout: flag sets on the edge closing the 8th busy cycle, then sticks.
        do_reset(1);
        for (int k = 1; k <= 10; k++) begin
            exp_st1 = (k == 1) ? 0 : 2;
            step("to_busy", busy_only, 1'b1, cw(2'(exp_st1), C_BUSY), 1'b0, '0);
            chk("to_flag", {31'd0, d1_to}, (k >= 9) ? 32'd1 : 32'd0);
        end
        step("to_exit", idle, 1'b1, cw(2'd2, C_DEF), 1'b0, '0);
        chk("to_sticky", {31'd0, d1_to}, 32'd1);
        step("to_idle", idle, 1'b1, cw(2'd0, C_DEF), 1'b0, '0);
        chk("to_sticky2", {31'd0, d1_to}, 32'd1);
        chk("to_stall_cnt", d1_stall, 32'd10);
        do_reset(1);
        step("to_cleared", idle, 1'b1, cw(2'd0, C_DEF), 1'b0, '0);
        chk("to_clear", {31'd0, d1_to}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
